// File: rtl/pipe_temp_scanner_pkg.sv
// Shared definitions for the multi-channel temperature scanner.
//   state_t      : frame FSM encoding
//   SYNC_BYTE_DEF: default frame header byte
//   FLG_*        : bit positions inside the FLG byte
//   UART_*       : link constants shared with the uArtTx side
package pipe_temp_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    CHN   = 3'd2,
    TMP_H = 3'd3,
    TMP_L = 3'd4,
    FLG   = 3'd5,
    CSUM  = 3'd6
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  localparam int FLG_ALARM = 0;
  localparam int FLG_SHDN  = 1;
  localparam int FLG_OVR   = 2;

  localparam int UART_BAUD_DIV  = 868;
  localparam bit UART_PARITY_EN = 1'b0;

  function automatic logic [7:0] flg_pack(input logic alm, input logic sd, input logic ovr);
    logic [7:0] f;
    f            = 8'h00;
    f[FLG_ALARM] = alm;
    f[FLG_SHDN]  = sd;
    f[FLG_OVR]   = ovr;
    return f;
  endfunction

endpackage

// File: rtl/pipe_temp_scanner_if.sv
// Byte stream from the scanner to the UART transmitter.
//   tx_data  : byte presented to the UART
//   tx_valid : tx_data is valid
//   tx_ready : UART accepts the byte this cycle
interface pipe_temp_scanner_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input  tx_ready);
  modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/pipe_temp_chan_eval.sv
// Per-channel evaluation.
//   sample          : live ADC reading (used at capture)
//   snap            : frozen snapshot reading (used for shutdown release)
//   alarm_q         : current alarm state of this channel
//   alarm_nxt       : alarm state to load if a capture happens now
//   sd_hit          : live sample at/above shutdown level
//   snap_sd_hit     : snapshot sample at/above shutdown level
module pipe_temp_chan_eval #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] sample,
  input  logic [DATA_W-1:0] snap,
  input  logic [DATA_W-1:0] alarm_thresh,
  input  logic [DATA_W-1:0] alarm_hyst,
  input  logic [DATA_W-1:0] shutdown_thresh,
  input  logic              alarm_q,
  output logic              alarm_nxt,
  output logic              sd_hit,
  output logic              snap_sd_hit
);

  // Release level saturates at 0 so a large margin never wraps around.
  logic [DATA_W-1:0] rel;
  assign rel = (alarm_thresh > alarm_hyst) ? (alarm_thresh - alarm_hyst) : '0;

  always_comb begin
    alarm_nxt = alarm_q;
    if (sample >= alarm_thresh)
      alarm_nxt = 1'b1;
    else if (sample < rel)
      alarm_nxt = 1'b0;
  end

  assign sd_hit      = (sample >= shutdown_thresh);
  assign snap_sd_hit = (snap >= shutdown_thresh);

endmodule

// File: rtl/pipe_temp_scanner.sv
// Multi-channel temperature scanner.
// Snapshots NUM_CH ADC readings on sample_tick, updates per-channel alarms
// (with hysteresis) and a latched shutdown, then streams one checksummed
// frame per channel: HDR, CHN, [TMP_H], TMP_L, FLG, CSUM.
//   clk, reset      : clock, synchronous active-high reset
//   sample_tick     : scan request
//   adc             : flattened samples, channel i at [i*DATA_W +: DATA_W]
//   alarm_thresh/alarm_hyst/shutdown_thresh : unsigned levels
//   shutdown_clr    : request to release the shutdown latch
//   tx              : byte valid/ready stream to uArtTx
//   alarm, shutdown, busy, overrun : status
module pipe_temp_scanner
  import pipe_temp_pkg::*;
#(
  parameter int         NUM_CH    = 4,
  parameter int         DATA_W    = 8,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sample_tick,
  input  logic [NUM_CH*DATA_W-1:0] adc,
  input  logic [DATA_W-1:0]        alarm_thresh,
  input  logic [DATA_W-1:0]        alarm_hyst,
  input  logic [DATA_W-1:0]        shutdown_thresh,
  input  logic                     shutdown_clr,
  pipe_temp_scanner_if.master      tx,
  output logic [NUM_CH-1:0]        alarm,
  output logic                     shutdown,
  output logic                     busy,
  output logic                     overrun
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_t                          state_q, state_d;
  logic [CH_W-1:0]                 ch_q;
  logic [NUM_CH-1:0][DATA_W-1:0]   adc_ch, snap_q;
  logic [NUM_CH-1:0]               alarm_q, alarm_nxt, sd_hit, snap_sd_hit;
  logic                            shutdown_q, overrun_q;
  logic [7:0]                      csum_q, flg_q, tx_byte;
  logic                            valid, xfer, capture, miss, last_ch;
  logic [DATA_W-1:0]               cur_s;
  logic                            cur_a;
  logic [15:0]                     cur16;

  assign adc_ch = adc;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pipe_temp_chan_eval #(.DATA_W(DATA_W)) u_eval (
      .sample          (adc_ch[i]),
      .snap            (snap_q[i]),
      .alarm_thresh    (alarm_thresh),
      .alarm_hyst      (alarm_hyst),
      .shutdown_thresh (shutdown_thresh),
      .alarm_q         (alarm_q[i]),
      .alarm_nxt       (alarm_nxt[i]),
      .sd_hit          (sd_hit[i]),
      .snap_sd_hit     (snap_sd_hit[i])
    );
  end

  assign valid   = (state_q != IDLE);
  assign xfer    = valid && tx.tx_ready;
  assign capture = (state_q == IDLE) && sample_tick;
  assign miss    = valid && sample_tick;
  assign last_ch = (ch_q == CH_W'(NUM_CH - 1));

  // Select the snapshot/alarm of the channel being framed.
  always_comb begin
    cur_s = '0;
    cur_a = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_q == CH_W'(i)) begin
        cur_s = snap_q[i];
        cur_a = alarm_q[i];
      end
    end
  end

  // Zero-extend to 16 bits so TMP_H/TMP_L are plain slices for any DATA_W.
  assign cur16 = 16'(cur_s);

  always_comb begin
    state_d = state_q;
    tx_byte = 8'h00;
    unique case (state_q)
      IDLE:  if (sample_tick) state_d = HDR;
      HDR:   begin
        tx_byte = SYNC_BYTE;
        if (xfer) state_d = CHN;
      end
      CHN:   begin
        tx_byte = 8'(ch_q);
        if (xfer) state_d = (DATA_W > 8) ? TMP_H : TMP_L;
      end
      TMP_H: begin
        tx_byte = cur16[15:8];
        if (xfer) state_d = TMP_L;
      end
      TMP_L: begin
        tx_byte = cur16[7:0];
        if (xfer) state_d = FLG;
      end
      FLG:   begin
        tx_byte = flg_q;
        if (xfer) state_d = CSUM;
      end
      CSUM:  begin
        tx_byte = csum_q;
        if (xfer) state_d = last_ch ? IDLE : HDR;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      snap_q     <= '0;
      alarm_q    <= '0;
      shutdown_q <= 1'b0;
      overrun_q  <= 1'b0;
      csum_q     <= 8'h00;
      flg_q      <= 8'h00;
    end else begin
      state_q <= state_d;

      if (capture) begin
        snap_q  <= adc_ch;
        alarm_q <= alarm_nxt;
        ch_q    <= '0;
      end else if (xfer && state_q == CSUM && !last_ch) begin
        ch_q <= ch_q + CH_W'(1);
      end

      // Set (new capture over limit) has priority over release.
      if (capture && |sd_hit)
        shutdown_q <= 1'b1;
      else if (shutdown_clr && !(|snap_sd_hit))
        shutdown_q <= 1'b0;

      if (miss)
        overrun_q <= 1'b1;
      else if (xfer && state_q == FLG && last_ch)
        overrun_q <= 1'b0;

      // Running XOR of the frame; restarts after each checksum byte.
      if (xfer)
        csum_q <= (state_q == CSUM) ? 8'h00 : (csum_q ^ tx_byte);

      // Flags are frozen when FLG is entered so the byte cannot change
      // while the UART is stalling.
      if (xfer && state_q == TMP_L)
        flg_q <= flg_pack(cur_a, shutdown_q, overrun_q);
    end
  end

  assign tx.tx_data  = tx_byte;
  assign tx.tx_valid = valid;
  assign alarm       = alarm_q;
  assign shutdown    = shutdown_q;
  assign busy        = valid;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_pipe_temp_scanner.sv
module tb_pipe_temp_scanner;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rst2  = 1'b1;
  always #5 clk = ~clk;

  // DUT1: 4 channels x 8 bits
  logic        tick1 = 1'b0, clr1 = 1'b0;
  logic [31:0] adc1 = '0;
  logic [7:0]  ath1 = 8'd80, ahy1 = 8'd5, sth1 = 8'd120;
  logic [3:0]  alarm1;
  logic        sd1, busy1, ovr1;
  pipe_temp_scanner_if tx1 ();

  // DUT2: 1 channel x 12 bits
  logic        tick2 = 1'b0, clr2 = 1'b0;
  logic [11:0] adc2 = '0;
  logic [11:0] ath2 = 12'h800, ahy2 = 12'h040, sth2 = 12'hF00;
  logic [0:0]  alarm2;
  logic        sd2, busy2, ovr2;
  pipe_temp_scanner_if tx2 ();

  pipe_temp_scanner #(.NUM_CH(4), .DATA_W(8)) dut1 (
    .clk(clk), .reset(reset), .sample_tick(tick1), .adc(adc1),
    .alarm_thresh(ath1), .alarm_hyst(ahy1), .shutdown_thresh(sth1),
    .shutdown_clr(clr1), .tx(tx1.master), .alarm(alarm1),
    .shutdown(sd1), .busy(busy1), .overrun(ovr1));

  pipe_temp_scanner #(.NUM_CH(1), .DATA_W(12)) dut2 (
    .clk(clk), .reset(rst2), .sample_tick(tick2), .adc(adc2),
    .alarm_thresh(ath2), .alarm_hyst(ahy2), .shutdown_thresh(sth2),
    .shutdown_clr(clr2), .tx(tx2.master), .alarm(alarm2),
    .shutdown(sd2), .busy(busy2), .overrun(ovr2));

  int nchk = 0, nfail = 0;
  logic [7:0] q1[$], q2[$];

  // reference model state
  int sv1[4];
  int snap1[4];
  bit m_alm1[4];
  bit m_sd1, m_ovr1;
  int sv2;
  bit m_alm2, m_sd2;
  bit rnd1 = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  function automatic bit alm_rule(input int s, input int th, input int hy, input bit prev);
    int rel;
    rel = th - hy;
    if (rel < 0) rel = 0;
    if (s >= th) return 1'b1;
    if (s < rel) return 1'b0;
    return prev;
  endfunction

  // One frame: A5, ch, [hi], lo, flags, xor of the preceding bytes.
  task automatic push_frame(input int dut, input int c, input int w, input int s,
                            input bit a, input bit sd, input bit ov);
    int b[$];
    int x;
    b.push_back(8'hA5);
    b.push_back(c);
    if (w > 8) b.push_back((s >> 8) & 255);
    b.push_back(s & 255);
    b.push_back(int'(a) + 2 * int'(sd) + 4 * int'(ov));
    x = 0;
    foreach (b[k]) x = x ^ b[k];
    b.push_back(x);
    foreach (b[k]) begin
      if (dut == 1) q1.push_back(8'(b[k]));
      else          q2.push_back(8'(b[k]));
    end
  endtask

  // ready: always 1, or 30% duty when rnd1 is set
  always @(posedge clk) begin
    #1;
    tx1.tx_ready = rnd1 ? ($urandom_range(0, 99) < 30) : 1'b1;
  end
  initial tx2.tx_ready = 1'b1;

  // monitors
  logic [7:0] prev1, prev2;
  bit stall1 = 1'b0, stall2 = 1'b0;

  always @(negedge clk) begin
    if (reset) stall1 <= 1'b0;
    else begin
      if (stall1)
        chk("stall_hold1", {23'b0, tx1.tx_valid, tx1.tx_data}, {23'b0, 1'b1, prev1});
      if (tx1.tx_valid && tx1.tx_ready) begin
        if (q1.size() == 0) chk("extra_byte1", {24'b0, tx1.tx_data}, 32'h100);
        else                chk("byte1", {24'b0, tx1.tx_data}, {24'b0, q1.pop_front()});
      end
      stall1 <= tx1.tx_valid && !tx1.tx_ready;
      prev1  <= tx1.tx_data;
    end
  end

  always @(negedge clk) begin
    if (rst2) stall2 <= 1'b0;
    else begin
      if (stall2)
        chk("stall_hold2", {23'b0, tx2.tx_valid, tx2.tx_data}, {23'b0, 1'b1, prev2});
      if (tx2.tx_valid && tx2.tx_ready) begin
        if (q2.size() == 0) chk("extra_byte2", {24'b0, tx2.tx_data}, 32'h100);
        else                chk("byte2", {24'b0, tx2.tx_data}, {24'b0, q2.pop_front()});
      end
      stall2 <= tx2.tx_valid && !tx2.tx_ready;
      prev2  <= tx2.tx_data;
    end
  end

  task automatic wait_idle(input int dut, output int cyc);
    logic b;
    cyc = 0;
    forever begin
      @(negedge clk);
      b = (dut == 1) ? busy1 : busy2;
      if (!b) break;
      cyc++;
      if (cyc >= 2000) begin
        chk("scan_timeout", {31'b0, b}, 32'd0);
        break;
      end
    end
  endtask

  task automatic set4(input int c0, input int c1, input int c2, input int c3);
    sv1[0] = c0; sv1[1] = c1; sv1[2] = c2; sv1[3] = c3;
  endtask

  function automatic logic [3:0] m_alm1_vec();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = m_alm1[i];
    return v;
  endfunction

  // Scan on DUT1. miss>=0 re-ticks that many cycles after capture.
  task automatic scan1(input int miss, input bit scramble, input int exp_busy);
    int cyc;
    bit any;
    any = 1'b0;
    for (int i = 0; i < 4; i++) begin
      snap1[i]  = sv1[i];
      m_alm1[i] = alm_rule(sv1[i], int'(ath1), int'(ahy1), m_alm1[i]);
      if (sv1[i] >= int'(sth1)) any = 1'b1;
    end
    if (any) m_sd1 = 1'b1;
    for (int i = 0; i < 4; i++) push_frame(1, i, 8, sv1[i], m_alm1[i], m_sd1, m_ovr1);
    m_ovr1 = 1'b0;
    @(posedge clk); #1;
    adc1  = {8'(sv1[3]), 8'(sv1[2]), 8'(sv1[1]), 8'(sv1[0])};
    tick1 = 1'b1;
    @(posedge clk); #1;
    tick1 = 1'b0;
    chk("alarm1", {28'b0, alarm1}, {28'b0, m_alm1_vec()});
    chk("shutdown1", {31'b0, sd1}, {31'b0, m_sd1});
    chk("busy1_start", {31'b0, busy1}, 32'd1);
    if (scramble) adc1 = $urandom;
    if (miss >= 0) begin
      repeat (miss) @(posedge clk);
      #1 tick1 = 1'b1;
      @(posedge clk); #1 tick1 = 1'b0;
      m_ovr1 = 1'b1;
    end
    wait_idle(1, cyc);
    if (exp_busy > 0) chk("busy_cycles", cyc, exp_busy);
    chk("q1_drained", q1.size(), 32'd0);
    chk("overrun1", {31'b0, ovr1}, {31'b0, m_ovr1});
  endtask

  task automatic clr1_pulse();
    bit any;
    any = 1'b0;
    for (int i = 0; i < 4; i++) if (snap1[i] >= int'(sth1)) any = 1'b1;
    if (!any) m_sd1 = 1'b0;
    @(posedge clk); #1 clr1 = 1'b1;
    @(posedge clk); #1 clr1 = 1'b0;
    chk("shutdown_clr1", {31'b0, sd1}, {31'b0, m_sd1});
  endtask

  task automatic scan2(input bit rst_mid);
    int cyc;
    m_alm2 = alm_rule(sv2, int'(ath2), int'(ahy2), m_alm2);
    if (sv2 >= int'(sth2)) m_sd2 = 1'b1;
    push_frame(2, 0, 12, sv2, m_alm2, m_sd2, 1'b0);
    @(posedge clk); #1;
    adc2  = 12'(sv2);
    tick2 = 1'b1;
    @(posedge clk); #1;
    tick2 = 1'b0;
    chk("alarm2", {31'b0, alarm2}, {31'b0, m_alm2});
    chk("shutdown2", {31'b0, sd2}, {31'b0, m_sd2});
    if (rst_mid) begin
      @(posedge clk); #1 rst2 = 1'b1;
      @(posedge clk); #1;
      chk("rst_valid2", {31'b0, tx2.tx_valid}, 32'd0);
      chk("rst_busy2", {31'b0, busy2}, 32'd0);
      chk("rst_alarm2", {31'b0, alarm2}, 32'd0);
      chk("rst_sd2", {31'b0, sd2}, 32'd0);
      chk("rst_data2", {24'b0, tx2.tx_data}, 32'd0);
      q2.delete();
      m_alm2 = 1'b0;
      m_sd2  = 1'b0;
      rst2   = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk("rst_stays_idle2", {31'b0, busy2}, 32'd0);
    end else begin
      wait_idle(2, cyc);
      chk("q2_drained", q2.size(), 32'd0);
    end
  endtask

  initial begin
    m_sd1 = 1'b0; m_ovr1 = 1'b0; m_alm2 = 1'b0; m_sd2 = 1'b0;
    for (int i = 0; i < 4; i++) begin m_alm1[i] = 1'b0; snap1[i] = 0; end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0; rst2 = 1'b0;
    @(negedge clk);
    chk("reset_valid", {31'b0, tx1.tx_valid}, 32'd0);
    chk("reset_data", {24'b0, tx1.tx_data}, 32'd0);
    chk("reset_busy", {31'b0, busy1}, 32'd0);
    chk("reset_alarm", {28'b0, alarm1}, 32'd0);
    chk("reset_sd_ovr", {30'b0, sd1, ovr1}, 32'd0);

    // basic frame set and hysteresis
    set4(10, 50, 90, 30); scan1(-1, 1'b0, 20);
    set4(10, 50, 77, 30); scan1(-1, 1'b0, 0);
    set4(10, 50, 74, 30); scan1(-1, 1'b0, 0);
    ath1 = 8'd3; ahy1 = 8'd10;
    set4(0, 5, 0, 0); scan1(-1, 1'b0, 0);
    set4(0, 0, 0, 0); scan1(-1, 1'b0, 0);
    ath1 = 8'd80; ahy1 = 8'd5;

    // shutdown latch
    set4(125, 50, 60, 30); scan1(-1, 1'b0, 0);
    clr1_pulse();
    set4(20, 50, 60, 30); scan1(-1, 1'b0, 0);
    clr1_pulse();

    // overrun: re-tick while the last checksum byte is presented
    set4(11, 22, 33, 44); scan1(19, 1'b0, 0);
    repeat (3) @(negedge clk);
    chk("missed_tick_no_scan", {31'b0, busy1}, 32'd0);
    set4(55, 66, 77, 88); scan1(-1, 1'b0, 0);

    // random samples with backpressure; adc disturbed mid-scan
    rnd1 = 1'b1;
    for (int n = 0; n < 8; n++) begin
      set4($urandom_range(60, 130), $urandom_range(60, 130),
           $urandom_range(60, 130), $urandom_range(60, 130));
      scan1(-1, 1'b1, 0);
      if (n % 3 == 2) clr1_pulse();
    end
    rnd1 = 1'b0;

    // 12-bit single channel, reset mid-frame, recovery
    sv2 = 12'hABC; scan2(1'b0);
    sv2 = 12'hF10; scan2(1'b1);
    sv2 = 12'h7F0; scan2(1'b0);

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
